// File: rtl/n_bit_one_to_four_dist.sv
// Buffered 1-to-4 distributor: one input word per cycle steered into one of four
// one-entry lane registers (directed, round-robin or broadcast), each draining on its own valid/ready.
module n_bit_one_to_four_dist #(
    parameter int N = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    input  logic [1:0]   in_sel,
    input  logic [1:0]   mode,
    output logic [3:0]   out_valid,
    input  logic [3:0]   out_ready,
    output logic [N-1:0] a,
    output logic [N-1:0] b,
    output logic [N-1:0] c,
    output logic [N-1:0] d,
    output logic [1:0]   rr_ptr
);

    localparam logic [1:0] MODE_RR    = 2'b01;
    localparam logic [1:0] MODE_BCAST = 2'b10;

    logic [3:0] tgt;
    logic [3:0] can;
    logic [3:0] load;
    logic [3:0] valid_nxt;
    logic       accept;

    // Reserved mode falls through to directed routing.
    always_comb begin
        tgt = 4'b0001 << in_sel;
        case (mode)
            MODE_RR:    tgt = 4'b0001 << rr_ptr;
            MODE_BCAST: tgt = 4'b1111;
            default:    tgt = 4'b0001 << in_sel;
        endcase
    end

    // A full lane being drained this cycle can be refilled in the same cycle.
    assign can      = ~out_valid | out_ready;
    assign in_ready = &(can | ~tgt);
    assign accept   = in_valid & in_ready;
    assign load     = accept ? tgt : 4'b0000;

    always_comb begin
        valid_nxt = out_valid;
        for (int k = 0; k < 4; k++) begin
            if (load[k]) begin
                valid_nxt[k] = 1'b1;
            end else if (out_valid[k] && out_ready[k]) begin
                valid_nxt[k] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 4'b0000;
            rr_ptr    <= 2'b00;
        end else begin
            out_valid <= valid_nxt;
            if (accept && (mode == MODE_RR)) begin
                rr_ptr <= rr_ptr + 2'd1;
            end
        end
    end

    // Lane data only moves on load and holds while the lane is empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a <= '0;
            b <= '0;
            c <= '0;
            d <= '0;
        end else begin
            if (load[0]) a <= in_data;
            if (load[1]) b <= in_data;
            if (load[2]) c <= in_data;
            if (load[3]) d <= in_data;
        end
    end

endmodule

// File: tb/tb_n_bit_one_to_four_dist.sv
// Directed self-checking bench for n_bit_one_to_four_dist; inputs change and outputs
// are sampled 1ns after the rising edge, well away from it.
module tb_n_bit_one_to_four_dist;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] in_data;
    logic [1:0] in_sel;
    logic [1:0] mode;
    logic [3:0] out_valid;
    logic [3:0] out_ready;
    logic [4:0] a, b, c, d;
    logic [1:0] rr_ptr;

    int total = 0;
    int bad   = 0;

    n_bit_one_to_four_dist #(.N(5)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_sel(in_sel), .mode(mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .a(a), .b(b), .c(c), .d(d),
        .rr_ptr(rr_ptr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_sel = '0; mode = '0; out_ready = '0;
        #2;
        total++;
        if ({out_valid, a, b, c, d, rr_ptr} !== 26'd0) begin
            bad++;
            $display("FAIL reset_state: ov=%b a=%h b=%h c=%h d=%h rr=%0d, want all 0", out_valid, a, b, c, d, rr_ptr);
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_directed();
        mode = 2'b00; in_sel = 2'b10; in_data = 5'h13; out_ready = 4'b0000; in_valid = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL dir_in_ready: got %b want 1", in_ready);
        end
        tick();
        total++;
        if ({out_valid, a, b, c, d} !== {4'b0100, 5'h00, 5'h00, 5'h13, 5'h00}) begin
            bad++;
            $display("FAIL dir_load: ov=%b a=%h b=%h c=%h d=%h, want ov=0100 c=13 others 0", out_valid, a, b, c, d);
        end
    endtask

    task automatic test_refill();
        in_data = 5'h07;
        #1;
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL full_stall_ready: got %b want 0", in_ready);
        end
        tick();
        total++;
        if ({out_valid, c} !== {4'b0100, 5'h13}) begin
            bad++;
            $display("FAIL full_stall_hold: ov=%b c=%h, want 0100 13", out_valid, c);
        end
        out_ready = 4'b0100;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL drain_ready: got %b want 1", in_ready);
        end
        tick();
        total++;
        if ({out_valid, c} !== {4'b0100, 5'h07}) begin
            bad++;
            $display("FAIL refill: ov=%b c=%h, want 0100 07", out_valid, c);
        end
        in_valid = 1'b0; out_ready = 4'b1111;
        tick();
        total++;
        if (out_valid !== 4'b0000) begin
            bad++;
            $display("FAIL drain_empty: ov=%b want 0000", out_valid);
        end
    endtask

    task automatic test_round_robin();
        logic [4:0] lane_val;
        mode = 2'b01; out_ready = 4'b1111; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = 5'(i + 1);
            #1;
            total++;
            if (rr_ptr !== 2'(i % 4)) begin
                bad++;
                $display("FAIL rr_ptr_seq[%0d]: got %0d want %0d", i, rr_ptr, i % 4);
            end
            tick();
            case (i % 4)
                0: lane_val = a;
                1: lane_val = b;
                2: lane_val = c;
                default: lane_val = d;
            endcase
            total++;
            if ({out_valid, lane_val} !== {4'b0001 << (i % 4), 5'(i + 1)}) begin
                bad++;
                $display("FAIL rr_load[%0d]: ov=%b lane=%h, want ov=%b lane=%h", i, out_valid, lane_val, 4'b0001 << (i % 4), i + 1);
            end
        end
        in_valid = 1'b0;
        tick();
        total++;
        if ({out_valid, rr_ptr, a, b, c, d} !== {4'b0000, 2'd1, 5'd5, 5'd2, 5'd3, 5'd4}) begin
            bad++;
            $display("FAIL rr_final: ov=%b rr=%0d a=%h b=%h c=%h d=%h, want 0000 1 5 2 3 4", out_valid, rr_ptr, a, b, c, d);
        end
    endtask

    task automatic test_broadcast();
        mode = 2'b00; in_sel = 2'b01; in_data = 5'h0A; out_ready = 4'b0000; in_valid = 1'b1;
        tick();
        mode = 2'b10; in_data = 5'h1F; out_ready = 4'b1101;
        #1;
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL bcast_stall_ready: got %b want 0", in_ready);
        end
        tick();
        total++;
        if ({out_valid, a, b, c, d} !== {4'b0010, 5'h05, 5'h0A, 5'h03, 5'h04}) begin
            bad++;
            $display("FAIL bcast_no_partial: ov=%b a=%h b=%h c=%h d=%h, want 0010 05 0a 03 04", out_valid, a, b, c, d);
        end
        out_ready = 4'b1111;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL bcast_ready: got %b want 1", in_ready);
        end
        tick();
        total++;
        if ({out_valid, a, b, c, d, rr_ptr} !== {4'b1111, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 2'd1}) begin
            bad++;
            $display("FAIL bcast_load: ov=%b a=%h b=%h c=%h d=%h rr=%0d, want 1111 all 1f rr 1", out_valid, a, b, c, d, rr_ptr);
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_mode_switch();
        mode = 2'b01; in_data = 5'h03; in_valid = 1'b1; out_ready = 4'b1111;
        tick();
        total++;
        if ({rr_ptr, b} !== {2'd2, 5'h03}) begin
            bad++;
            $display("FAIL rr_to_2: rr=%0d b=%h, want 2 03", rr_ptr, b);
        end
        mode = 2'b00;
        for (int i = 0; i < 3; i++) begin
            in_sel = 2'(i); in_data = 5'(5'h10 + i);
            tick();
        end
        mode = 2'b11; in_sel = 2'b11; in_data = 5'h15;
        tick();
        total++;
        if ({out_valid, d, rr_ptr} !== {4'b1000, 5'h15, 2'd2}) begin
            bad++;
            $display("FAIL reserved_mode: ov=%b d=%h rr=%0d, want 1000 15 2", out_valid, d, rr_ptr);
        end
        total++;
        if ({a, b, c} !== {5'h10, 5'h11, 5'h12}) begin
            bad++;
            $display("FAIL directed_words: a=%h b=%h c=%h, want 10 11 12", a, b, c);
        end
        mode = 2'b01; in_data = 5'h09;
        #1;
        total++;
        if (rr_ptr !== 2'd2) begin
            bad++;
            $display("FAIL rr_preserved: got %0d want 2", rr_ptr);
        end
        tick();
        total++;
        if ({out_valid, c, rr_ptr} !== {4'b0100, 5'h09, 2'd3}) begin
            bad++;
            $display("FAIL rr_resume: ov=%b c=%h rr=%0d, want 0100 09 3", out_valid, c, rr_ptr);
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_async_reset();
        mode = 2'b00; out_ready = 4'b0000; in_valid = 1'b1;
        in_sel = 2'b00; in_data = 5'h01; tick();
        in_sel = 2'b01; in_data = 5'h02; tick();
        in_sel = 2'b11; in_data = 5'h04; tick();
        in_valid = 1'b0;
        total++;
        if ({out_valid, rr_ptr} !== {4'b1011, 2'd3}) begin
            bad++;
            $display("FAIL pre_reset: ov=%b rr=%0d, want 1011 3", out_valid, rr_ptr);
        end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if ({out_valid, a, b, c, d, rr_ptr} !== 26'd0) begin
            bad++;
            $display("FAIL async_reset: ov=%b a=%h b=%h c=%h d=%h rr=%0d, want all 0", out_valid, a, b, c, d, rr_ptr);
        end
        tick();
        rst = 1'b0;
        tick();
        total++;
        if ({out_valid, a, b, c, d} !== 24'd0) begin
            bad++;
            $display("FAIL post_reset_idle: ov=%b a=%h b=%h c=%h d=%h, want all 0", out_valid, a, b, c, d);
        end
        test_directed();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_refill();
        test_round_robin();
        test_broadcast();
        test_mode_switch();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
